// File: rtl/psg_ecfs_lvdcdc_sd_adc_dec.sv
// Sinc3 decimator and comb section for the sigma-delta ADC path.
// Samples the free-running third integrator once per M-clock window, runs
// three comb (differentiator) stages at the decimated rate, normalises the
// result to 16 bits and strobes it out. After any restart the first three
// decimated samples only refill comb history, so no stale output escapes.
module psg_ecfs_lvdcdc_sd_adc_dec #(
  parameter int DATA_W = 22,
  parameter int OUT_W  = 16
) (
  input  logic              clk_adc,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] cn_in,
  input  logic              enable,
  input  logic              sync,
  input  logic [1:0]        dec_rate,
  output logic [OUT_W-1:0]  dout,
  output logic              dout_valid
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    RUN  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [1:0]        decRate_q;
  logic [6:0]        count_q, count_d;
  logic [6:0]        lastCount;
  logic [1:0]        prime_q, prime_d;
  logic [3:0]        shAmt;
  logic              restart;
  logic              flush;
  logic              takeSample;
  logic              emit;

  logic [DATA_W-1:0] d0Prev_q;
  logic [DATA_W-1:0] c1_q, c1Prev_q;
  logic [DATA_W-1:0] c2_q, c2Prev_q;
  logic [DATA_W-1:0] c3_q;
  logic [DATA_W-1:0] norm;
  logic              v1_q, e1_q;
  logic              v2_q, e2_q;
  logic              e3_q;
  logic              adv1, adv2, adv3;
  logic [OUT_W-1:0]  normSat;
  logic [OUT_W-1:0]  dout_q;
  logic              doutValid_q;

  // A sync pulse or any change of the rate select restarts the window.
  assign restart = enable & (sync | (dec_rate != decRate_q));

  // Window length and normalising shift for the selected decimation rate.
  always_comb begin
    lastCount = 7'd127;
    shAmt     = 4'd0;
    case (decRate_q)
      2'd0: begin lastCount = 7'd15;  shAmt = 4'd9; end
      2'd1: begin lastCount = 7'd31;  shAmt = 4'd6; end
      2'd2: begin lastCount = 7'd63;  shAmt = 4'd3; end
      default: begin lastCount = 7'd127; shAmt = 4'd0; end
    endcase
  end

  // Next-state logic: window counter, priming counter and sample strobe.
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    prime_d    = prime_q;
    flush      = 1'b0;
    takeSample = 1'b0;
    emit       = 1'b0;
    if (!enable) begin
      state_d = IDLE;
      count_d = 7'd0;
      prime_d = 2'd0;
      flush   = 1'b1;
    end else if (restart) begin
      state_d = FILL;
      count_d = 7'd0;
      prime_d = 2'd0;
      flush   = 1'b1;
    end else begin
      if (count_q == lastCount) begin
        count_d    = 7'd0;
        takeSample = (state_q != IDLE);
      end else begin
        count_d = count_q + 7'd1;
      end
      case (state_q)
        IDLE: begin
          state_d = FILL;
          prime_d = 2'd0;
        end
        FILL: begin
          if (takeSample) begin
            if (prime_q == 2'd2) begin
              state_d = RUN;
              prime_d = 2'd0;
            end else begin
              prime_d = prime_q + 2'd1;
            end
          end
        end
        RUN: begin
          emit = takeSample;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // Control registers: state, window counter, priming count, registered rate.
  always_ff @(posedge clk_adc or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      count_q   <= 7'd0;
      prime_q   <= 2'd0;
      decRate_q <= 2'd0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      prime_q   <= prime_d;
      decRate_q <= dec_rate;
    end
  end

  // A stage only advances when its input is valid and no restart is pending.
  assign adv1 = v1_q & ~flush;
  assign adv2 = v2_q & ~flush;
  assign adv3 = e3_q & ~flush;

  // Shift to full scale 2^21; values at or above 2^21 saturate to all ones.
  assign norm    = c3_q << shAmt;
  assign normSat = norm[DATA_W-1] ? {OUT_W{1'b1}} : norm[DATA_W-2 -: OUT_W];

  // Comb pipeline: the sample feeds c1 directly, then c2, c3, output register.
  always_ff @(posedge clk_adc or negedge reset_n) begin
    if (!reset_n) begin
      d0Prev_q    <= '0;
      c1_q        <= '0;
      c1Prev_q    <= '0;
      c2_q        <= '0;
      c2Prev_q    <= '0;
      c3_q        <= '0;
      v1_q        <= 1'b0;
      e1_q        <= 1'b0;
      v2_q        <= 1'b0;
      e2_q        <= 1'b0;
      e3_q        <= 1'b0;
      dout_q      <= '0;
      doutValid_q <= 1'b0;
    end else begin
      v1_q <= takeSample;
      e1_q <= emit;
      if (takeSample) begin
        c1_q     <= cn_in - d0Prev_q;
        d0Prev_q <= cn_in;
      end
      v2_q <= adv1;
      e2_q <= e1_q & adv1;
      if (adv1) begin
        c2_q     <= c1_q - c1Prev_q;
        c1Prev_q <= c1_q;
      end
      e3_q <= e2_q & adv2;
      if (adv2) begin
        c3_q     <= c2_q - c2Prev_q;
        c2Prev_q <= c2_q;
      end
      doutValid_q <= adv3;
      if (adv3) begin
        dout_q <= normSat;
      end
    end
  end

  assign dout       = dout_q;
  assign dout_valid = doutValid_q;

endmodule

// File: tb/tb_psg_ecfs_lvdcdc_sd_adc_dec.sv
// Testbench for the Sinc3 decimator/comb block. cn_in comes from a
// bit-accurate three-stage integrator model fed by a pattern bitstream.
module tb_psg_ecfs_lvdcdc_sd_adc_dec;

  localparam int PAT_ZERO    = 0;
  localparam int PAT_ONES    = 1;
  localparam int PAT_ALT     = 2;
  localparam int PAT_QUARTER = 3;

  logic        clk_adc = 1'b0;
  logic        reset_n;
  logic [21:0] cn_in;
  logic        enable;
  logic        sync;
  logic [1:0]  dec_rate;
  logic [15:0] dout;
  logic        dout_valid;

  int          checks = 0;
  int          failures = 0;
  int          validCount = 0;
  int          pattern = PAT_ZERO;
  int          bitIdx = 0;
  logic [21:0] i1 = '0;
  logic [21:0] i2 = '0;
  logic [21:0] i3 = '0;

  typedef struct {
    int         pat;
    logic [1:0] rate;
    bit         preload;
    int         expVal;
    string      name;
  } vec_t;

  vec_t vecs[6];

  // 100 MHz ADC clock
  always #5 clk_adc = ~clk_adc;

  psg_ecfs_lvdcdc_sd_adc_dec dut (
    .clk_adc    (clk_adc),
    .reset_n    (reset_n),
    .cn_in      (cn_in),
    .enable     (enable),
    .sync       (sync),
    .dec_rate   (dec_rate),
    .dout       (dout),
    .dout_valid (dout_valid)
  );

  // One clock: wait for the edge, then advance the integrator model and count strobes.
  task automatic applyStimulus();
    logic b;
    @(posedge clk_adc);
    #1;
    case (pattern)
      PAT_ONES:    b = 1'b1;
      PAT_ALT:     b = ((bitIdx % 2) == 0);
      PAT_QUARTER: b = ((bitIdx % 4) == 0);
      default:     b = 1'b0;
    endcase
    bitIdx = bitIdx + 1;
    i1 = i1 + {21'd0, b};
    i2 = i2 + i1;
    i3 = i3 + i2;
    cn_in = i3;
    if (dout_valid) validCount = validCount + 1;
  endtask

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks = checks + 1;
    if (actual !== expected) begin
      failures = failures + 1;
      $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)",
               name, actual, actual, expected, expected);
    end
  endtask

  // Step until dout_valid is seen; n = clocks taken, or -1 on timeout.
  task automatic waitValid(input int limit, output int n, output int val);
    n = 0;
    val = -1;
    do begin
      applyStimulus();
      n = n + 1;
    end while (!dout_valid && n < limit);
    if (dout_valid) val = int'(dout);
    else n = -1;
  endtask

  // Idle the block, select pattern and rate, enable and check the first strobe.
  task automatic startRun(input int pat, input logic [1:0] rate, input bit preload,
                          input int expVal, input string tag);
    int m;
    int n;
    int v;
    m = 16 << rate;
    enable = 1'b0;
    repeat (3) applyStimulus();
    pattern  = pat;
    bitIdx   = 0;
    dec_rate = rate;
    repeat (3) applyStimulus();
    if (preload) begin
      i1 = '0;
      i2 = '0;
      i3 = 22'h3FFFF0;
      cn_in = i3;
    end
    enable = 1'b1;
    waitValid(4 * m + 3 + 8, n, v);
    checkOutput({tag, " first latency"}, n, 4 * m + 3);
    checkOutput({tag, " first value"}, v, expVal);
  endtask

  initial begin
    int n;
    int v;
    int m;
    int vc;

    vecs[0] = '{PAT_ONES,    2'd3, 1'b0, 32'hFFFF, "ones M128"};
    vecs[1] = '{PAT_ALT,     2'd2, 1'b0, 32'h8000, "alt M64"};
    vecs[2] = '{PAT_ALT,     2'd0, 1'b0, 32'h8000, "alt M16"};
    vecs[3] = '{PAT_ZERO,    2'd1, 1'b0, 32'h0000, "zero M32"};
    vecs[4] = '{PAT_QUARTER, 2'd1, 1'b1, 32'h4000, "quarter wrap M32"};
    vecs[5] = '{PAT_ONES,    2'd0, 1'b0, 32'hFFFF, "ones M16"};

    reset_n  = 1'b0;
    enable   = 1'b0;
    sync     = 1'b0;
    dec_rate = 2'd0;
    cn_in    = '0;
    repeat (2) applyStimulus();
    checkOutput("reset dout", int'(dout), 0);
    checkOutput("reset dout_valid", int'(dout_valid), 0);
    reset_n = 1'b1;
    applyStimulus();

    for (int k = 0; k < 6; k++) begin
      m = 16 << vecs[k].rate;
      startRun(vecs[k].pat, vecs[k].rate, vecs[k].preload, vecs[k].expVal, vecs[k].name);
      for (int j = 0; j < 2; j++) begin
        waitValid(m + 8, n, v);
        checkOutput({vecs[k].name, " period"}, n, m);
        checkOutput({vecs[k].name, " value"}, v, vecs[k].expVal);
      end
    end

    startRun(PAT_ALT, 2'd2, 1'b0, 32'h8000, "sync base");
    repeat (10) applyStimulus();
    sync = 1'b1;
    applyStimulus();
    sync = 1'b0;
    waitValid(4 * 64 + 3 + 8, n, v);
    checkOutput("sync mid latency", n, 4 * 64 + 3);
    checkOutput("sync mid value", v, 32'h8000);

    repeat (64 - 4) applyStimulus();
    sync = 1'b1;
    applyStimulus();
    sync = 1'b0;
    waitValid(4 * 64 + 3 + 8, n, v);
    checkOutput("sync at S latency", n, 4 * 64 + 3);
    checkOutput("sync at S value", v, 32'h8000);

    startRun(PAT_ALT, 2'd3, 1'b0, 32'h8000, "rate base");
    repeat (20) applyStimulus();
    dec_rate = 2'd1;
    waitValid(4 * 32 + 4 + 8, n, v);
    checkOutput("rate change latency", n, 4 * 32 + 4);
    checkOutput("rate change value", v, 32'h8000);
    waitValid(32 + 8, n, v);
    checkOutput("rate change period", n, 32);

    repeat (32 - 2) applyStimulus();
    enable = 1'b0;
    vc = validCount;
    repeat (12) applyStimulus();
    checkOutput("enable drop strobes", validCount - vc, 0);
    checkOutput("enable drop dout held", int'(dout), 32'h8000);
    checkOutput("enable drop dout_valid", int'(dout_valid), 0);

    startRun(PAT_ALT, 2'd0, 1'b0, 32'h8000, "reset base");
    repeat (5) applyStimulus();
    reset_n = 1'b0;
    #2;
    checkOutput("async reset dout", int'(dout), 0);
    checkOutput("async reset dout_valid", int'(dout_valid), 0);
    repeat (2) applyStimulus();
    reset_n = 1'b1;
    waitValid(4 * 16 + 3 + 8, n, v);
    checkOutput("post reset latency", n, 4 * 16 + 3);
    checkOutput("post reset value", v, 32'h8000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
